memory_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of `memory_controller`. It shares the single PDP-8 memory between requester 0 (CPU fetch/execute) and requester 1 (front-panel/loader). It accepts one request at a time and drives the controller's enables for a fixed access window. It returns read data with a one-cycle done pulse and never asserts read and write enables together.

---
 rtl/memory_utils_pkg.sv | 23 ++
 rtl/memory_arb_picker.sv | 33 +++
 rtl/memory_arbiter.sv | 149 ++++++++++++++
 tb/tb_memory_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_utils_pkg.sv
// Shared PDP-8 memory types plus the arbiter state encoding and requester count.
package memory_utils;

    localparam int WORD_W = 12;
    typedef logic [WORD_W-1:0] word;

    localparam logic DATA_READ         = 1'b0;
    localparam logic INSTRUCTION_FETCH = 1'b1;

    localparam int NUM_MEM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } arb_state_t;

    // Index of the set bit in a two-requester one-hot vector.
    function automatic logic onehot_idx(input logic [NUM_MEM_REQ-1:0] oh);
        return oh[1];
    endfunction

endpackage

// File: rtl/memory_arb_picker.sv
// Combinational winner selection for the two memory requesters.
// MEM_ARB_FIXED_PRIO_EN: requester 0 always wins ties and 'last' is ignored.
module memory_arb_picker
    import memory_utils::*;
(
    input  logic [NUM_MEM_REQ-1:0] req,
    input  logic                   last,
    output logic [NUM_MEM_REQ-1:0] winner
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        winner = '0;
        if (req[0]) begin
            winner = 2'b01;
        end else if (req[1]) begin
            winner = 2'b10;
        end
    end
`else
    // On a tie the requester that was not served last time wins.
    always_comb begin
        winner = req;
        if (req == 2'b11) begin
            winner = last ? 2'b01 : 2'b10;
        end
    end
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Two-port arbiter/sequencer in front of memory_controller: one access at a time,
// fixed enable window, one-cycle gnt/done pulses. MEM_ARB_FIXED_PRIO_EN selects fixed priority.
module memory_arbiter
    import memory_utils::*;
#(
    parameter int ACCESS_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MEM_REQ-1:0] req,
    input  logic [NUM_MEM_REQ-1:0] we,
    input  logic [NUM_MEM_REQ-1:0] rtype,
    input  word                    addr0,
    input  word                    addr1,
    input  word                    wdata0,
    input  word                    wdata1,
    output logic [NUM_MEM_REQ-1:0] gnt,
    output logic [NUM_MEM_REQ-1:0] done,
    output word                    rdata,
    output word                    mem_address,
    output word                    mem_write_data,
    output logic                   mem_read_enable,
    output logic                   mem_write_enable,
    output logic                   mem_read_type,
    input  word                    mem_read_data
);

    localparam int              CNT_W    = $clog2(ACCESS_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    arb_state_t              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_MEM_REQ-1:0]  sel_q, sel_d;
    logic [NUM_MEM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_MEM_REQ-1:0]  done_q, done_d;
    word                     rdata_q, rdata_d;
    word                     addr_q, addr_d;
    word                     wdata_q, wdata_d;
    logic                    rd_en_q, rd_en_d;
    logic                    wr_en_q, wr_en_d;
    logic                    rtype_q, rtype_d;
    logic                    last_q, last_d;
    logic [NUM_MEM_REQ-1:0]  winner;
    logic                    win_idx;

    memory_arb_picker u_picker (
        .req    (req),
        .last   (last_q),
        .winner (winner)
    );

    assign win_idx = onehot_idx(winner);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        gnt_d   = '0;
        done_d  = '0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_en_d = rd_en_q;
        wr_en_d = wr_en_q;
        rtype_d = rtype_q;
        last_d  = last_q;

        unique case (state_q)
            IDLE: begin
                if (|winner) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_LOAD;
                    sel_d   = winner;
                    gnt_d   = winner;
                    addr_d  = win_idx ? addr1 : addr0;
                    wdata_d = win_idx ? wdata1 : wdata0;
                    // Enables are decoded from a single bit, so they can never overlap.
                    wr_en_d = we[win_idx];
                    rd_en_d = ~we[win_idx];
                    rtype_d = rtype[win_idx];
                    last_d  = win_idx;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = COMPLETE;
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b0;
                    done_d  = sel_q;
                    if (rd_en_q) begin
                        rdata_d = mem_read_data;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            COMPLETE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            rtype_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            rtype_q <= rtype_d;
`ifdef MEM_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;
`else
            last_q  <= last_d;
`endif
        end
    end

    assign gnt              = gnt_q;
    assign done             = done_q;
    assign rdata            = rdata_q;
    assign mem_address      = addr_q;
    assign mem_write_data   = wdata_q;
    assign mem_read_enable  = rd_en_q;
    assign mem_write_enable = wr_en_q;
    assign mem_read_type    = rtype_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: one instance at ACCESS_CYCLES=1, one at 3, each with a memory model.
module tb_memory_arbiter;
    import memory_utils::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0] req_a, we_a, rtype_a, gnt_a, done_a;
    word        addr0_a, addr1_a, wdata0_a, wdata1_a, rdata_a, maddr_a, mwd_a, mrd_a;
    logic       mre_a, mwe_a, mrt_a;

    logic [1:0] req_b, we_b, rtype_b, gnt_b, done_b;
    word        addr0_b, addr1_b, wdata0_b, wdata1_b, rdata_b, maddr_b, mwd_b, mrd_b;
    logic       mre_b, mwe_b, mrt_b;

    word  mem_a [0:4095];
    word  mem_b [0:4095];
    logic pl_en, pl_sel;
    word  pl_addr, pl_data;

    always @(posedge clk) begin
        if (pl_en && !pl_sel) mem_a[pl_addr] <= pl_data;
        else if (mwe_a)       mem_a[maddr_a] <= mwd_a;
    end
    always @(posedge clk) begin
        if (pl_en && pl_sel) mem_b[pl_addr] <= pl_data;
        else if (mwe_b)      mem_b[maddr_b] <= mwd_b;
    end
    assign mrd_a = mem_a[maddr_a];
    assign mrd_b = mem_b[maddr_b];

    memory_arbiter #(.ACCESS_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .req(req_a), .we(we_a), .rtype(rtype_a),
        .addr0(addr0_a), .addr1(addr1_a), .wdata0(wdata0_a), .wdata1(wdata1_a),
        .gnt(gnt_a), .done(done_a), .rdata(rdata_a),
        .mem_address(maddr_a), .mem_write_data(mwd_a),
        .mem_read_enable(mre_a), .mem_write_enable(mwe_a), .mem_read_type(mrt_a),
        .mem_read_data(mrd_a)
    );

    memory_arbiter #(.ACCESS_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .req(req_b), .we(we_b), .rtype(rtype_b),
        .addr0(addr0_b), .addr1(addr1_b), .wdata0(wdata0_b), .wdata1(wdata1_b),
        .gnt(gnt_b), .done(done_b), .rdata(rdata_b),
        .mem_address(maddr_b), .mem_write_data(mwd_b),
        .mem_read_enable(mre_b), .mem_write_enable(mwe_b), .mem_read_type(mrt_b),
        .mem_read_data(mrd_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic sel, input word a, input word d);
        pl_en = 1'b1; pl_sel = sel; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    int exp_tie [4];

    initial begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_tie = '{1, 1, 1, 1};
`else
        exp_tie = '{1, 2, 1, 2};
`endif
        rst = 1'b1; pl_en = 1'b0; pl_sel = 1'b0; pl_addr = '0; pl_data = '0;
        req_a = '0; we_a = '0; rtype_a = '0; addr0_a = '0; addr1_a = '0; wdata0_a = '0; wdata1_a = '0;
        req_b = '0; we_b = '0; rtype_b = '0; addr0_b = '0; addr1_b = '0; wdata0_b = '0; wdata1_b = '0;

        preload(1'b0, 12'o0200, 12'o7402);
        preload(1'b0, 12'o0100, 12'o1111);
        preload(1'b0, 12'o0101, 12'o2222);
        preload(1'b1, 12'o0000, 12'o1234);
        tick();

        check("reset_gnt_done", 64'({gnt_a, done_a}), 64'(0));
        check("reset_enables", 64'({mre_a, mwe_a, mrt_a}), 64'(0));
        check("reset_data", 64'({rdata_a, maddr_a, mwd_a}), 64'(0));
        rst = 1'b0;
        tick();

        // Requester 0 data read of 0200
        req_a = 2'b01; we_a = 2'b00; rtype_a = 2'b00; addr0_a = 12'o0200;
        tick();
        check("rd0200_gnt", 64'(gnt_a), 64'(2'b01));
        check("rd0200_en", 64'({mre_a, mwe_a, mrt_a}), 64'(3'b100));
        check("rd0200_addr", 64'(maddr_a), 64'(12'o0200));
        req_a = 2'b00;
        tick();
        check("rd0200_done", 64'(done_a), 64'(2'b01));
        check("rd0200_rdata", 64'(rdata_a), 64'(12'o7402));
        check("rd0200_en_off", 64'({mre_a, mwe_a}), 64'(0));
        $display("txn read r0 addr=0200 rdata=%0o", rdata_a);
        tick();
        check("rd0200_done_pulse", 64'(done_a), 64'(0));

        // Requester 1 writes 5555 to 0017
        req_a = 2'b10; we_a = 2'b10; addr1_a = 12'o0017; wdata1_a = 12'o5555;
        tick();
        check("wr0017_gnt", 64'(gnt_a), 64'(2'b10));
        check("wr0017_en", 64'({mre_a, mwe_a}), 64'(2'b01));
        check("wr0017_wdata", 64'(mwd_a), 64'(12'o5555));
        req_a = 2'b00; we_a = 2'b00;
        tick();
        check("wr0017_done", 64'(done_a), 64'(2'b10));
        check("wr0017_en_off", 64'({mre_a, mwe_a}), 64'(0));
        check("wr0017_rdata_held", 64'(rdata_a), 64'(12'o7402));
        check("wr0017_mem", 64'(mem_a[12'o0017]), 64'(12'o5555));
        $display("txn write r1 addr=0017 wdata=5555");
        tick();

        // Requester 0 reads it back
        req_a = 2'b01; addr0_a = 12'o0017;
        tick();
        check("rd0017_gnt", 64'(gnt_a), 64'(2'b01));
        check("rd0017_en", 64'({mre_a, mwe_a}), 64'(2'b10));
        req_a = 2'b00;
        tick();
        check("rd0017_done", 64'(done_a), 64'(2'b01));
        check("rd0017_rdata", 64'(rdata_a), 64'(12'o5555));
        $display("txn read r0 addr=0017 rdata=%0o", rdata_a);
        tick();

        // Ties from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_a = 2'b11; we_a = 2'b00; addr0_a = 12'o0100; addr1_a = 12'o0101;
            tick();
            check($sformatf("tie%0d_gnt", i), 64'(gnt_a), 64'(exp_tie[i]));
            req_a = 2'b00;
            tick();
            check($sformatf("tie%0d_done", i), 64'(done_a), 64'(exp_tie[i]));
            check($sformatf("tie%0d_rdata", i), 64'(rdata_a),
                  64'((exp_tie[i] == 1) ? 12'o1111 : 12'o2222));
            $display("txn tie %0d done=%0b rdata=%0o", i, done_a, rdata_a);
            tick();
        end

        // A request raised while busy waits for the next IDLE cycle
        req_a = 2'b01; addr0_a = 12'o0200;
        tick();
        check("busy_gnt0", 64'(gnt_a), 64'(2'b01));
        req_a = 2'b10; addr1_a = 12'o0017;
        tick();
        check("busy_complete", 64'({gnt_a, done_a}), 64'(4'b0001));
        tick();
        check("busy_idle_gnt", 64'(gnt_a), 64'(0));
        tick();
        check("busy_gnt1", 64'(gnt_a), 64'(2'b10));
        req_a = 2'b00;
        tick();
        check("busy_done1", 64'(done_a), 64'(2'b10));
        check("busy_rdata1", 64'(rdata_a), 64'(12'o5555));
        $display("txn read r1 addr=0017 after wait rdata=%0o", rdata_a);
        tick();

        // Reset in the first ACCESS cycle of a read
        req_a = 2'b01; addr0_a = 12'o0200;
        tick();
        check("abort_gnt", 64'(gnt_a), 64'(2'b01));
        req_a = 2'b00; rst = 1'b1;
        tick();
        check("abort_outputs",
              64'({gnt_a, done_a, mre_a, mwe_a, mrt_a, maddr_a, mwd_a, rdata_a}), 64'(0));
        rst = 1'b0;
        tick();
        check("abort_no_done", 64'(done_a), 64'(0));
        req_a = 2'b01; addr0_a = 12'o0017;
        tick();
        check("after_abort_gnt", 64'(gnt_a), 64'(2'b01));
        req_a = 2'b00;
        tick();
        check("after_abort_done", 64'(done_a), 64'(2'b01));
        check("after_abort_rdata", 64'(rdata_a), 64'(12'o5555));
        $display("txn abort then read r0 addr=0017 rdata=%0o", rdata_a);
        tick();

        // ACCESS_CYCLES=3 instruction fetch of 0000; address change mid-access is ignored
        req_b = 2'b01; rtype_b = 2'b01; addr0_b = 12'o0000;
        tick();
        check("if3_gnt", 64'(gnt_b), 64'(2'b01));
        req_b = 2'b00; addr0_b = 12'o0777;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("if3_en_c%0d", c), 64'({mre_b, mwe_b, mrt_b}), 64'(3'b101));
            check($sformatf("if3_addr_c%0d", c), 64'(maddr_b), 64'(0));
            check($sformatf("if3_nodone_c%0d", c), 64'(done_b), 64'(0));
            tick();
        end
        check("if3_done", 64'(done_b), 64'(2'b01));
        check("if3_en_off", 64'({mre_b, mwe_b}), 64'(0));
        check("if3_rdata", 64'(rdata_b), 64'(12'o1234));
        $display("txn fetch r0 addr=0000 ac=3 rdata=%0o", rdata_b);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
